// File: rtl/serial_tx_ctrl_pkg.sv
// Shared types and constants for the serial transmit sequencer.
// Holds the state encoding, the parity modes and the data-length decode.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE, FETCH, CHECK, START, DATA, PARITY, STOP, BREAK
   } tx_state_t;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'b00,
      PAR_EVEN  = 2'b01,
      PAR_ODD   = 2'b10,
      PAR_NINTH = 2'b11
   } parity_mode_t;

   localparam logic [1:0] DBITS_5 = 2'b00;
   localparam logic [1:0] DBITS_6 = 2'b01;
   localparam logic [1:0] DBITS_7 = 2'b10;
   localparam logic [1:0] DBITS_8 = 2'b11;

   localparam int DIV_MIN = 2;

   // Index of the last data bit: 4..7 for 5..8 bits.
   function automatic logic [2:0] last_data_idx(input logic [1:0] db);
      return 3'd4 + {1'b0, db};
   endfunction

   function automatic logic [7:0] data_mask(input logic [1:0] db);
      case (db)
         DBITS_5: return 8'h1F;
         DBITS_6: return 8'h3F;
         DBITS_7: return 8'h7F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/serial_tx_ctrl_if.sv
// FIFO read-side bundle between the TX FIFO (slave) and the sequencer (master).
// Read data and index are registered inside the FIFO; the pop strobe is one cycle.
interface serial_tx_ctrl_if;
   logic       fifo_empty;
   logic [8:0] fifo_rd_data;
   logic [4:0] fifo_rd_index;
   logic       fifo_rd_request;

   modport master (input fifo_empty, fifo_rd_data, fifo_rd_index, output fifo_rd_request);
   modport slave  (output fifo_empty, fifo_rd_data, fifo_rd_index, input fifo_rd_request);
endinterface

// File: rtl/serial_tx_ctrl_baud.sv
// Loadable down-counter giving a bit-boundary tick every i_div cycles.
// Load restarts the period; the tick marks the last cycle of each bit.
module serial_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);
   localparam logic [DIV_W-1:0] LP_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

   logic [DIV_W-1:0] r_period;
   logic [DIV_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_period <= '0;
         r_cnt    <= '0;
      end else if (i_load) begin
         r_period <= i_div;
         r_cnt    <= i_div - LP_ONE;
      end else if (r_cnt == '0) begin
         r_cnt    <= r_period - LP_ONE;
      end else begin
         r_cnt    <= r_cnt - LP_ONE;
      end
   end

   assign o_tick = (r_cnt == '0) && !i_load;
endmodule

// File: rtl/serial_tx_ctrl.sv
// Async-frame transmit sequencer: pops the TX FIFO, confirms the pop by index, serialises.
// Two idle cycles (FETCH, CHECK) between frames; optional line break under SERIAL_TX_BREAK_EN.
module serial_tx_ctrl
   import serial_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [DIV_W-1:0]       divisor,
   input  logic [1:0]             data_bits,
   input  logic [1:0]             parity_mode,
   input  logic                   two_stop,
   input  logic                   break_req,
   serial_tx_ctrl_if.master       fifo,
   output logic                   tx,
   output logic                   busy,
   output logic                   frame_done
);
   localparam logic [DIV_W-1:0] LP_DIV_MIN = DIV_W'(DIV_MIN);

   tx_state_t        r_state, w_next;
   logic [4:0]       r_idx_snap;
   logic [8:0]       r_shift;
   logic [2:0]       r_bit_cnt;
   logic [2:0]       r_last_bit;
   parity_mode_t     r_par_mode;
   logic             r_par_bit;
   logic             r_two_stop;

   logic             w_tick;
   logic             w_pop_ok;
   logic             w_start_ok;
   logic             w_last_stop;
   logic             w_data_xor;
   logic             w_par;
   logic [DIV_W-1:0] w_div_eff;

`ifndef SERIAL_TX_BREAK_EN
   logic w_unused_break;
   assign w_unused_break = break_req;
`endif

   assign w_div_eff   = (divisor < LP_DIV_MIN) ? LP_DIV_MIN : divisor;
   // A changed read pointer is the only proof the pop was not overridden by a write.
   assign w_pop_ok    = (fifo.fifo_rd_index != r_idx_snap);
   assign w_start_ok  = enable && !fifo.fifo_empty;
   assign w_last_stop = r_two_stop ? (r_bit_cnt == 3'd1) : 1'b1;
   assign w_data_xor  = ^(fifo.fifo_rd_data[7:0] & data_mask(data_bits));

   always_comb begin
      w_par = 1'b0;
      case (parity_mode_t'(parity_mode))
         PAR_EVEN:  w_par = w_data_xor;
         PAR_ODD:   w_par = ~w_data_xor;
         PAR_NINTH: w_par = fifo.fifo_rd_data[8];
         default:   w_par = 1'b0;
      endcase
   end

   serial_baud_tick #(.DIV_W(DIV_W)) u_baud (
      .clk    (clk),
      .reset  (reset),
      .i_load (r_state == CHECK),
      .i_div  (w_div_eff),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
`ifdef SERIAL_TX_BREAK_EN
            if (break_req)       w_next = BREAK;
            else
`endif
            if (w_start_ok)      w_next = FETCH;
         end
         FETCH:                  w_next = CHECK;
         CHECK: begin
            if (w_pop_ok)        w_next = START;
            else if (w_start_ok) w_next = FETCH;
            else                 w_next = IDLE;
         end
         START:  if (w_tick)     w_next = DATA;
         DATA: begin
            if (w_tick && r_bit_cnt == r_last_bit)
               w_next = (r_par_mode != PAR_NONE) ? PARITY : STOP;
         end
         PARITY: if (w_tick)     w_next = STOP;
         STOP: begin
            if (w_tick && w_last_stop)
               w_next = w_start_ok ? FETCH : IDLE;
         end
`ifdef SERIAL_TX_BREAK_EN
         BREAK:  if (!break_req) w_next = IDLE;
`endif
         default:                w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_idx_snap <= '0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_last_bit <= '0;
         r_par_mode <= PAR_NONE;
         r_par_bit  <= 1'b0;
         r_two_stop <= 1'b0;
      end else begin
         case (r_state)
            FETCH: r_idx_snap <= fifo.fifo_rd_index;
            CHECK: begin
               if (w_pop_ok) begin
                  r_shift    <= fifo.fifo_rd_data;
                  r_last_bit <= last_data_idx(data_bits);
                  r_par_mode <= parity_mode_t'(parity_mode);
                  r_par_bit  <= w_par;
                  r_two_stop <= two_stop;
                  r_bit_cnt  <= '0;
               end
            end
            DATA: begin
               if (w_tick) begin
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= (r_bit_cnt == r_last_bit) ? 3'd0 : r_bit_cnt + 3'd1;
               end
            end
            STOP: if (w_tick) r_bit_cnt <= r_bit_cnt + 3'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      tx                   = 1'b1;
      busy                 = (r_state != IDLE);
      frame_done           = 1'b0;
      fifo.fifo_rd_request = 1'b0;
      case (r_state)
         FETCH:  fifo.fifo_rd_request = 1'b1;
         START:  tx = 1'b0;
         DATA:   tx = r_shift[0];
         PARITY: tx = r_par_bit;
         STOP:   frame_done = w_tick && w_last_stop;
`ifdef SERIAL_TX_BREAK_EN
         BREAK:  tx = 1'b0;
`endif
         default: ;
      endcase
   end
endmodule
